keypad_code_controller: RTL and testbench

- Sequencer for the 10-bit key latch bank. It consumes latched key levels, detects new key presses and checks them in order against a stored code.
- Drives unlock, error and lockout status, and pulses a clear request back to the latch bank after every evaluation or timeout.
- Sits between the latch bank and the door/indicator logic.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_edge_detect.sv | 32 +++
 rtl/keypad_code_controller.sv | 152 +++++++++++++++
 tb/tb_keypad_code_controller.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad code controller.
// Digit decode treats a rise vector with exactly one bit set as a valid key.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, ENTRY, UNLOCKED, LOCKOUT} kp_state_t;

  localparam int NUM_KEYS = 10;

  typedef struct packed {
    logic       vld;
    logic [3:0] dat;
  } digit_t;

  function automatic digit_t onehot_to_digit(input logic [NUM_KEYS-1:0] v);
    digit_t      r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        n++;
        r.dat = 4'(i);
      end
    end
    r.vld = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_edge_detect.sv
// Registers the latched key levels and reports new presses (0->1 rises).
// A rise on more than one key in the same cycle is flagged as multi.
module keypad_edge_detect
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [3:0]          digit,
  output logic                valid,
  output logic                multi
);

  logic [NUM_KEYS-1:0] keys_q;
  logic [NUM_KEYS-1:0] rise;
  digit_t              dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q <= '0;
    end else begin
      keys_q <= keys;
    end
  end

  assign rise  = keys & ~keys_q;
  assign dec   = onehot_to_digit(rise);
  assign digit = dec.dat;
  assign valid = dec.vld;
  assign multi = (rise != '0) && !dec.vld;

endmodule

// File: rtl/keypad_code_controller.sv
// Keypad code sequencer: checks presses against CODE, drives unlock/error/lockout
// status and pulses clear_latches after each evaluation, timeout or lockout exit.
module keypad_code_controller
  import keypad_pkg::*;
#(
  parameter int          CODE_LEN       = 5,
  parameter logic [31:0] CODE           = 32'h0002_4680,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          UNLOCK_CYCLES  = 2000,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 5000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                clear_latches,
  output logic                unlocked,
  output logic                error,
  output logic                locked_out,
  output logic [3:0]          digits_entered
);

  localparam int HOLD_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] UNL_LAST  = HW'(UNLOCK_CYCLES - 1);
  localparam logic [HW-1:0] LCK_LAST  = HW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [3:0]    LEN       = 4'(CODE_LEN);

  function automatic logic [3:0] code_digit(input logic [3:0] idx);
    return 4'(CODE >> (4 * (CODE_LEN - 1 - int'(idx))));
  endfunction

  kp_state_t     state_q;
  logic [3:0]    digits_q, digits_d;
  logic          mism_q, mism_d;
  logic [FW-1:0] fails_q;
  logic [TW-1:0] tmo_q;
  logic [HW-1:0] hold_q;
  logic          clear_q, unlocked_q, error_q, locked_q;

  logic [3:0]    key_digit;
  logic          key_valid, key_multi, press;

  keypad_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .keys  (keys),
    .digit (key_digit),
    .valid (key_valid),
    .multi (key_multi)
  );

  // In IDLE digits_q and mism_q are zero, so one expression serves both states.
  always_comb begin
    press    = key_valid | key_multi;
    digits_d = digits_q + 4'd1;
    mism_d   = mism_q | key_multi | (key_digit != code_digit(digits_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      mism_q     <= 1'b0;
      fails_q    <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      clear_q    <= 1'b0;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE, ENTRY: begin
          if (press) begin
            tmo_q <= '0;
            if (digits_d == LEN) begin
              digits_q <= '0;
              mism_q   <= 1'b0;
              clear_q  <= ~clear_q;
              hold_q   <= '0;
              if (!mism_d) begin
                state_q    <= UNLOCKED;
                unlocked_q <= 1'b1;
                fails_q    <= '0;
              end else begin
                error_q <= 1'b1;
                if (fails_q >= FAIL_LAST) begin
                  state_q  <= LOCKOUT;
                  locked_q <= 1'b1;
                  fails_q  <= '0;
                end else begin
                  state_q <= IDLE;
                  fails_q <= fails_q + 1'b1;
                end
              end
            end else begin
              state_q  <= ENTRY;
              digits_q <= digits_d;
              mism_q   <= mism_d;
            end
          end else if (state_q == ENTRY) begin
            if (tmo_q == TMO_LAST) begin
              state_q  <= IDLE;
              digits_q <= '0;
              mism_q   <= 1'b0;
              tmo_q    <= '0;
              clear_q  <= ~clear_q;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        UNLOCKED: begin
          if (hold_q == UNL_LAST) begin
            state_q    <= IDLE;
            unlocked_q <= 1'b0;
            hold_q     <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        LOCKOUT: begin
          // Exit flushes anything latched while presses were being ignored.
          if (hold_q == LCK_LAST) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            hold_q   <= '0;
            clear_q  <= ~clear_q;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clear_latches  = clear_q;
  assign unlocked       = unlocked_q;
  assign error          = error_q;
  assign locked_out     = locked_q;
  assign digits_entered = digits_q;

endmodule

// File: tb/tb_keypad_code_controller.sv
// Bench for keypad_code_controller: directed scenarios plus randomized attempts
// predicted from the code digits and the consecutive-failure rule.
module tb_keypad_code_controller;

  localparam int CODE_LEN       = 5;
  localparam int CODE           = 32'h0002_4680;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int UNLOCK_CYCLES  = 2000;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 5000;

  typedef logic [9:0] mask_arr_t [5];

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] keys  = '0;
  logic       clear_latches, unlocked, error, locked_out;
  logic [3:0] digits_entered;

  int n_tests = 0;
  int n_fail  = 0;
  int model_fails = 0;

  keypad_code_controller #(
    .CODE_LEN       (CODE_LEN),
    .CODE           (CODE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .keys           (keys),
    .clear_latches  (clear_latches),
    .unlocked       (unlocked),
    .error          (error),
    .locked_out     (locked_out),
    .digits_entered (digits_entered)
  );

  always #5 clk = ~clk;

  // Reference: digit k is the k-th hex nibble from the most significant used one.
  function automatic int ref_digit(input int k);
    return (CODE / (16 ** (CODE_LEN - 1 - k))) % 16;
  endfunction

  function automatic bit ref_ok(input mask_arr_t m);
    for (int k = 0; k < CODE_LEN; k++)
      if (m[k] != 10'(1 << ref_digit(k))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] k, input int gap);
    repeat (gap) step();
    keys = k;
    step();
  endtask

  task automatic wait_high(input bit which, input int bound, output int n);
    n = 0;
    while (((which == 1'b0) ? unlocked : locked_out) && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic wait_clear(input int bound, output int n);
    n = 0;
    while (!clear_latches && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) step();
    n_tests++;
    if ({clear_latches, unlocked, error, locked_out, digits_entered} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%b want 00000000", {clear_latches, unlocked, error, locked_out, digits_entered});
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({clear_latches, unlocked, error, locked_out, digits_entered} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%b want 00000000", {clear_latches, unlocked, error, locked_out, digits_entered});
    end
    model_fails = 0;
  endtask

  task automatic test_unlock();
    logic [9:0] k;
    int n;
    k = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      k = k | (10'b1 << ref_digit(i));
      press(k, 20);
      if (i < CODE_LEN - 1) begin
        n_tests++;
        if (digits_entered !== 4'(i + 1)) begin
          n_fail++;
          $display("FAIL unlock_digits: got %0d want %0d", digits_entered, i + 1);
        end
      end
    end
    n_tests++;
    if ({clear_latches, unlocked, error, digits_entered} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL unlock_eval: clr/unl/err/dig=%b want 1100000", {clear_latches, unlocked, error, digits_entered});
    end
    wait_high(1'b0, 3000, n);
    n_tests++;
    if (n != UNLOCK_CYCLES) begin
      n_fail++;
      $display("FAIL unlock_duration: got %0d want %0d", n, UNLOCK_CYCLES);
    end
    n_tests++;
    if ({clear_latches, unlocked} !== 2'b00) begin
      n_fail++;
      $display("FAIL unlock_exit: clr/unl=%b want 00", {clear_latches, unlocked});
    end
    model_fails = 0;
    keys = '0;
  endtask

  task automatic test_fail_lockout();
    logic [9:0] k;
    int d, n;
    bit exp_lock;
    for (int a = 0; a < MAX_FAILS; a++) begin
      keys = '0;
      k = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
        d = (i == CODE_LEN - 1) ? (ref_digit(i) + 1) % 10 : ref_digit(i);
        k = k | (10'b1 << d);
        press(k, 20);
      end
      model_fails++;
      exp_lock = (model_fails == MAX_FAILS);
      if (exp_lock) model_fails = 0;
      n_tests++;
      if ({error, clear_latches, unlocked, locked_out} !== {1'b1, 1'b1, 1'b0, exp_lock}) begin
        n_fail++;
        $display("FAIL fail_eval[%0d]: err/clr/unl/lck=%b want 110%0b", a, {error, clear_latches, unlocked, locked_out}, exp_lock);
      end
      if (!exp_lock) begin
        step();
        n_tests++;
        if ({error, clear_latches} !== 2'b00) begin
          n_fail++;
          $display("FAIL fail_pulse_width: err/clr=%b want 00", {error, clear_latches});
        end
      end else begin
        n = 0;
        keys = '0;
        while (locked_out && n < 6000) begin
          if (n == 100) keys = 10'h001;
          if (n == 300) keys = 10'h005;
          if (n == 400) begin
            n_tests++;
            if ({digits_entered, unlocked, error} !== 6'b0) begin
              n_fail++;
              $display("FAIL lockout_ignore: dig/unl/err=%b want 000000", {digits_entered, unlocked, error});
            end
          end
          step();
          n++;
        end
        n_tests++;
        if (n != LOCKOUT_CYCLES) begin
          n_fail++;
          $display("FAIL lockout_duration: got %0d want %0d", n, LOCKOUT_CYCLES);
        end
        n_tests++;
        if (clear_latches !== 1'b1) begin
          n_fail++;
          $display("FAIL lockout_exit_clear: got %b want 1", clear_latches);
        end
        keys = '0;
        step();
        n_tests++;
        if ({clear_latches, digits_entered} !== 5'b0) begin
          n_fail++;
          $display("FAIL lockout_clear_single: clr/dig=%b want 00000", {clear_latches, digits_entered});
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [9:0] k;
    int n;
    keys = '0;
    k = 10'b1 << ref_digit(0);
    press(k, 20);
    k = k | (10'b1 << ref_digit(1));
    press(k, 20);
    n_tests++;
    if (digits_entered !== 4'd2) begin
      n_fail++;
      $display("FAIL timeout_digits: got %0d want 2", digits_entered);
    end
    wait_clear(1500, n);
    n_tests++;
    if (n != TIMEOUT_CYCLES) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT_CYCLES);
    end
    n_tests++;
    if ({clear_latches, digits_entered, error} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_no_error: clr/dig/err=%b want 1000000", {clear_latches, digits_entered, error});
    end
    keys = '0;
    k = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      k = k | (10'b1 << ref_digit(i));
      press(k, 5);
    end
    n_tests++;
    if ({unlocked, error} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_then_unlock: unl/err=%b want 10", {unlocked, error});
    end
    wait_high(1'b0, 3000, n);
    model_fails = 0;
    keys = '0;
  endtask

  task automatic test_multi();
    logic [9:0] k;
    keys = '0;
    k = (10'b1 << ref_digit(0)) | 10'h028;
    press(k, 20);
    n_tests++;
    if (digits_entered !== 4'd1) begin
      n_fail++;
      $display("FAIL multi_first: got %0d want 1", digits_entered);
    end
    for (int i = 1; i < CODE_LEN; i++) begin
      k = k | (10'b1 << ref_digit(i));
      press(k, 20);
    end
    model_fails++;
    n_tests++;
    if ({error, unlocked, clear_latches} !== 3'b101) begin
      n_fail++;
      $display("FAIL multi_error: err/unl/clr=%b want 101", {error, unlocked, clear_latches});
    end
    keys = '0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [9:0] k;
    int n;
    keys = '0;
    k = '0;
    for (int i = 0; i < 3; i++) begin
      k = k | (10'b1 << ref_digit(i));
      press(k, 10);
    end
    n_tests++;
    if (digits_entered !== 4'd3) begin
      n_fail++;
      $display("FAIL reset_mid_digits: got %0d want 3", digits_entered);
    end
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({clear_latches, unlocked, error, locked_out, digits_entered} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%b want 00000000", {clear_latches, unlocked, error, locked_out, digits_entered});
    end
    keys = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_fails = 0;
    k = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      k = k | (10'b1 << ref_digit(i));
      press(k, 5);
    end
    n_tests++;
    if ({unlocked, error, clear_latches} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_then_unlock: unl/err/clr=%b want 101", {unlocked, error, clear_latches});
    end
    wait_high(1'b0, 3000, n);
    keys = '0;
  endtask

  task automatic test_random();
    mask_arr_t m;
    int kind, pos, d, n;
    bit ok, exp_lock;
    for (int a = 0; a < 6; a++) begin
      kind = $urandom_range(0, 3);
      pos  = $urandom_range(0, CODE_LEN - 1);
      for (int i = 0; i < CODE_LEN; i++) m[i] = 10'b1 << ref_digit(i);
      if (kind == 2) begin
        d = (ref_digit(pos) + 1 + $urandom_range(0, 8)) % 10;
        m[pos] = 10'b1 << d;
      end else if (kind == 3) begin
        d = (ref_digit(pos) + 1 + $urandom_range(0, 8)) % 10;
        m[pos] = m[pos] | (10'b1 << d);
      end
      for (int i = 0; i < CODE_LEN; i++) begin
        press('0, $urandom_range(1, 30));
        press(m[i], 0);
        if (i < CODE_LEN - 1) begin
          n_tests++;
          if (digits_entered !== 4'(i + 1)) begin
            n_fail++;
            $display("FAIL rand_digits[%0d.%0d]: got %0d want %0d", a, i, digits_entered, i + 1);
          end
        end
      end
      ok = ref_ok(m);
      exp_lock = 1'b0;
      if (ok) begin
        model_fails = 0;
      end else begin
        model_fails++;
        if (model_fails == MAX_FAILS) begin
          exp_lock = 1'b1;
          model_fails = 0;
        end
      end
      n_tests++;
      if ({clear_latches, unlocked, error, locked_out} !== {1'b1, ok, !ok, exp_lock}) begin
        n_fail++;
        $display("FAIL rand_eval[%0d]: clr/unl/err/lck=%b want 1%0b%0b%0b", a, {clear_latches, unlocked, error, locked_out}, ok, !ok, exp_lock);
      end
      keys = '0;
      if (ok) begin
        wait_high(1'b0, 3000, n);
        n_tests++;
        if (n != UNLOCK_CYCLES) begin
          n_fail++;
          $display("FAIL rand_unlock_len[%0d]: got %0d want %0d", a, n, UNLOCK_CYCLES);
        end
      end else if (exp_lock) begin
        wait_high(1'b1, 6000, n);
        n_tests++;
        if (n != LOCKOUT_CYCLES || clear_latches !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_lockout[%0d]: len=%0d clr=%b want %0d 1", a, n, clear_latches, LOCKOUT_CYCLES);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail_lockout();
    test_timeout();
    test_multi();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
